delay_timer: RTL and testbench

//   Parametrised programmable delay timer for SPI device sequencing (power-up

---
 rtl/delay_timer_if.sv | 31 +++
 rtl/delay_timer.sv | 145 ++++++++++++++
 tb/tb_delay_timer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/delay_timer_if.sv
// ============================================================================
//  Module      : delay_timer_if
//  Description : Start/abort request and busy/done/remaining status bundle
//                between a sequencing FSM (master) and delay_timer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface delay_timer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             abort;
   logic             periodic;
   logic [CNT_W-1:0] delay_val;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;

   modport master (
      output start, abort, periodic, delay_val,
      input  busy, done, remaining
   );

   modport slave (
      input  start, abort, periodic, delay_val,
      output busy, done, remaining
   );
endinterface

`default_nettype wire

// File: rtl/delay_timer.sv
// ============================================================================
//  Module      : delay_timer
//  Description : Programmable tick-based delay timer (one-shot / periodic)
//                with a clock prescaler, retrigger and abort.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module delay_timer #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1_000_000,
   parameter int CNT_W   = 16
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   delay_timer_if.slave tmr
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   // One spare bit keeps PRESCALE=1 legal (zero-width counter otherwise).
   localparam int PS_W     = $clog2(PRESCALE) + 1;

   localparam logic [PS_W-1:0]  c_PS_MAX = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_ZERO   = '0;

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;

   logic [PS_W-1:0]  r_presc;
   logic [PS_W-1:0]  w_presc_nxt;
   logic [CNT_W-1:0] r_rem;
   logic [CNT_W-1:0] w_rem_nxt;
   logic [CNT_W-1:0] r_reload;
   logic [CNT_W-1:0] w_reload_nxt;
   logic             r_periodic;
   logic             w_periodic_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;

   logic             w_tick;
   logic             w_expire;
   logic             w_start_zero;

   assign w_tick       = (r_state == c_RUN) && (r_presc == c_PS_MAX);
   assign w_expire     = w_tick && (r_rem == c_ONE);
   assign w_start_zero = (tmr.delay_val == c_ZERO);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: abort beats start, start beats expiry
   always_comb begin
      w_state_nxt = r_state;
      if (tmr.abort) begin
         w_state_nxt = c_IDLE;
      end else if (tmr.start) begin
         w_state_nxt = w_start_zero ? c_IDLE : c_RUN;
      end else if (w_expire && !r_periodic) begin
         w_state_nxt = c_IDLE;
      end
   end

   // Next values of the prescaler, counter, latched request and status
   always_comb begin
      w_presc_nxt    = r_presc;
      w_rem_nxt      = r_rem;
      w_reload_nxt   = r_reload;
      w_periodic_nxt = r_periodic;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      if (tmr.abort) begin
         w_presc_nxt = '0;
         w_rem_nxt   = '0;
         w_busy_nxt  = 1'b0;
      end else if (tmr.start) begin
         w_presc_nxt = '0;
         if (w_start_zero) begin
            // Zero-length delay completes at once; mode is not latched.
            w_rem_nxt  = '0;
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
         end else begin
            w_rem_nxt      = tmr.delay_val;
            w_reload_nxt   = tmr.delay_val;
            w_periodic_nxt = tmr.periodic;
            w_busy_nxt     = 1'b1;
         end
      end else if (r_state == c_RUN) begin
         if (w_tick) begin
            w_presc_nxt = '0;
            if (w_expire) begin
               w_done_nxt = 1'b1;
               if (r_periodic) begin
                  w_rem_nxt = r_reload;
               end else begin
                  w_rem_nxt  = '0;
                  w_busy_nxt = 1'b0;
               end
            end else begin
               w_rem_nxt = r_rem - 1'b1;
            end
         end else begin
            w_presc_nxt = r_presc + 1'b1;
         end
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc    <= '0;
         r_rem      <= '0;
         r_reload   <= '0;
         r_periodic <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_presc    <= w_presc_nxt;
         r_rem      <= w_rem_nxt;
         r_reload   <= w_reload_nxt;
         r_periodic <= w_periodic_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign tmr.busy      = r_busy;
   assign tmr.done      = r_done;
   assign tmr.remaining = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_delay_timer.sv
// ============================================================================
//  Module      : tb_delay_timer
//  Description : Randomized + directed bench for delay_timer against a
//                deadline-based reference model (PRESCALE=4 and PRESCALE=1).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_delay_timer;

   localparam int P = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   delay_timer_if #(.CNT_W(8)) bus ();
   delay_timer_if #(.CNT_W(8)) bus1 ();

   delay_timer #(.CLK_HZ(100), .TICK_HZ(25), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tmr   (bus)
   );

   delay_timer #(.CLK_HZ(25), .TICK_HZ(25), .CNT_W(8)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .tmr   (bus1)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: absolute cycle of the next expiry
   int   mcyc;
   int   m_deadline;
   int   m_n;
   logic m_per;
   logic m_busy;
   logic m_done;
   int   m_rem;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mcyc = 0; m_deadline = 0; m_n = 0; m_per = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
   endtask

   task automatic model_edge(input logic s, input logic a, input logic p, input int n);
      mcyc++;
      m_done = 1'b0;
      if (a) begin
         m_busy = 1'b0;
      end else if (s) begin
         if (n != 0) begin
            m_busy = 1'b1; m_n = n; m_per = p; m_deadline = mcyc + n * P;
         end else begin
            m_busy = 1'b0; m_done = 1'b1;
         end
      end else if (m_busy && mcyc == m_deadline) begin
         m_done = 1'b1;
         if (m_per) m_deadline = m_deadline + m_n * P;
         else       m_busy = 1'b0;
      end
      // ticks still to go, rounded up
      m_rem = m_busy ? (m_deadline - mcyc + P - 1) / P : 0;
   endtask

   task automatic step(input logic s, input logic a, input logic p, input logic [7:0] n);
      bus.start = s; bus.abort = a; bus.periodic = p; bus.delay_val = n;
      @(posedge clk);
      model_edge(s, a, p, int'(n));
      #1;
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("remaining", 32'(bus.remaining), 32'(m_rem));
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
   endtask

   initial begin
      int cnt;
      bus.start = 1'b0; bus.abort = 1'b0; bus.periodic = 1'b0; bus.delay_val = '0;
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.periodic = 1'b0; bus1.delay_val = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rem", 32'(bus.remaining), 32'd0);
      rst_n = 1'b1;
      idle(3);

      // one-shot N=3
      step(1'b1, 1'b0, 1'b0, 8'd3);
      idle(14);
      // periodic N=2, abort at k+18
      step(1'b1, 1'b0, 1'b1, 8'd2);
      idle(17);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      idle(10);
      // retrigger N=5 -> N=1 at k+6
      step(1'b1, 1'b0, 1'b0, 8'd5);
      idle(5);
      step(1'b1, 1'b0, 1'b0, 8'd1);
      idle(8);
      // zero delay, then start+abort together
      step(1'b1, 1'b0, 1'b1, 8'd0);
      idle(3);
      step(1'b1, 1'b1, 1'b0, 8'd3);
      idle(4);
      // start on the expiry edge of a one-shot N=1
      step(1'b1, 1'b0, 1'b0, 8'd1);
      idle(3);
      step(1'b1, 1'b0, 1'b0, 8'd1);
      idle(6);
      // maximum delay at PRESCALE=4
      step(1'b1, 1'b0, 1'b0, 8'd255);
      idle(1025);

      // asynchronous reset mid-run
      step(1'b1, 1'b0, 1'b1, 8'd5);
      idle(7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_rem", 32'(bus.remaining), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      model_reset();
      #1;
      idle(30);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic       s, a, p;
         logic [7:0] n;
         s = ($urandom_range(0, 15) == 0);
         a = ($urandom_range(0, 40) == 0);
         p = 1'($urandom);
         n = ($urandom_range(0, 30) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         step(s, a, p, n);
      end
      bus.start = 1'b0; bus.abort = 1'b0;

      // PRESCALE=1 build: N=255 one-shot
      bus1.start = 1'b1; bus1.delay_val = 8'd255; bus1.periodic = 1'b0;
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      chk("p1_busy", 32'(bus1.busy), 32'd1);
      chk("p1_rem", 32'(bus1.remaining), 32'd255);
      cnt = 0;
      while (!bus1.done && cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("p1_latency", 32'(cnt), 32'd255);
      chk("p1_busy_end", 32'(bus1.busy), 32'd0);
      @(posedge clk);
      #1;
      chk("p1_done_once", 32'(bus1.done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
